shared_mem_arbiter: RTL
=======================

# shared_mem_arbiter

Parametrised banked shared-memory subsystem serving the GPU core array: N cores issue byte-wide load/store requests to B interleaved single-port banks. Each bank runs its own round-robin arbiter, grants at most one access per cycle and returns a one-cycle `finish` pulse to the served core. Identical-address reads to the same bank are optionally coalesced into a single access. This block replaces the per-bank arbiter instances plus the external finish-OR network in the GPU top level.

## Interface
- `NUM_CORES`, 16, number of requesting cores N (≥2)
- `NUM_BANKS`, 16, number of banks B (power of two, ≥2)
- `ADDR_W`, 12, core address width; bank = `addr[log2(B)-1:0]`, word = `addr[ADDR_W-1:log2(B)]`
- `DATA_W`, 8, data word width
- `COALESCE`, 1, 1 = same-address reads on a bank are served together; 0 = strictly one core per bank per cycle

- `clk`  in  1  sole clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `read`  in  N  per-core load request, level, held until `finish`
- `write`  in  N  per-core store request, level, held until `finish`
- `addr_in`  in  N*ADDR_W  core i address at `[i*ADDR_W +: ADDR_W]`
- `data_in`  in  N*DATA_W  core i store data at `[i*DATA_W +: DATA_W]`
- `data_out`  out  N*DATA_W  core i load result, held until next load completes
- `finish`  out  N  one-cycle completion pulse per core

## Operation
- Per bank b, eligible core set = cores with (`read|write`) set, bank field == b, and not granted in the previous cycle (finish pending).
- `read` and `write` both high on a core: treated as write.
- Winner = first eligible core at or after `rr_ptr[b]`, scanning upward with wrap N-1→0.
- On a grant to core k: `rr_ptr[b]` ← (k+1) mod N. No grant: pointer unchanged.
- Winner write: bank word ← core data. Winner read: bank word read (synchronous RAM).
- COALESCE=1 and winner is a read: every other eligible core on bank b with `read` high, `write` low and identical full address is co-granted; all receive the same data and `finish`. Pointer advances past the winner only.
- Each core targets one bank, so a core is granted by at most one bank per cycle; `finish`/`data_out` muxing needs no extra priority.
- Memory contents are not reset; uninitialised reads return X in sim.
- Per-bank state: `rr_ptr` (log2(N) bits), registered grant vector (N bits), registered read flag.

## Timing
- Grant decided combinationally in cycle t from inputs sampled at t.
- `finish[k]` = 1 in cycle t+1 for every core granted at t (read or write); `data_out[k]` valid from cycle t+1 for reads and held afterwards.
- Core is required to drop its request in the cycle after seeing `finish`; the exclusion rule means a request still high during the finish cycle is not re-granted then. A request still high one cycle after `finish` is a new access.
- Throughput: one access (or one coalesced read group) per bank per cycle; with B banks up to B cores complete per cycle.
- Write at t followed by read of same address granted at t+1: read returns the new value (no bypass needed, write commits at end of t).
- Same-bank read and write in same cycle from different cores: only the round-robin winner proceeds; write is never coalesced.
- Starvation bound: a continuously requesting core is granted within N cycles of becoming eligible on its bank.
- Reset: `finish` = 0, `data_out` = 0, all `rr_ptr` = 0, grant registers cleared, from the cycle after `reset` is sampled high. Reset asserted in the cycle following a grant suppresses that grant's `finish`; the write itself may or may not have committed.

## Test plan
- Single core 3 writes 0xA5 to addr 0x013 at t, then reads 0x013 -> `finish[3]` at t+1 and t+3 (with one idle cycle), `data_out[3]` = 0xA5 at t+3.
- Cores 0,1,2 all read bank 5 (different words) continuously after reset -> finishes in order 0,1,2, each one cycle apart, then pointer wraps; no core finishes twice before the others.
- 16 cores each hit a distinct bank in same cycle -> all 16 `finish` bits high one cycle later.
- COALESCE=1: cores 2,7,9 read addr 0x044 simultaneously, holding 0x3C -> all three `finish` together at t+1 with `data_out` = 0x3C; COALESCE=0 -> three finishes over three grants, ptr order.
- Core 4 writes 0x11 and core 6 reads same address same cycle, ptr=0 -> core 4 granted first, core 6 read then returns 0x11.
- Reset pulsed the cycle after a grant -> no `finish`, all outputs 0, next request from core 0 served first.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
//   Banked shared memory for the core array. NUM_CORES cores issue byte-wide loads and stores
//   to NUM_BANKS address-interleaved single-port banks. Each bank has its own round-robin
//   arbiter that grants one access per cycle. With COALESCE=1, a read winner's same-address
//   reads on that bank are served in the same cycle. Every served core gets a one-cycle
//   finish pulse in the following cycle.
//
// Ports
//   clk       sole clock, rising edge
//   reset     synchronous, active-high
//   read      per-core load request (level, held until finish)
//   write     per-core store request (level, held until finish); wins over read
//   addr_in   core i address at [i*ADDR_W +: ADDR_W]; low log2(NUM_BANKS) bits select bank
//   data_in   core i store data at [i*DATA_W +: DATA_W]
//   data_out  core i load result, valid from the finish cycle and held until the next load
//   finish    one-cycle completion pulse per core
module shared_mem_arbiter #(
    parameter int unsigned NUM_CORES = 16,
    parameter int unsigned NUM_BANKS = 16,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 8,
    parameter bit          COALESCE  = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        read,
    input  logic [NUM_CORES-1:0]        write,
    input  logic [NUM_CORES*ADDR_W-1:0] addr_in,
    input  logic [NUM_CORES*DATA_W-1:0] data_in,
    output logic [NUM_CORES*DATA_W-1:0] data_out,
    output logic [NUM_CORES-1:0]        finish
);

    localparam int unsigned CoreW = $clog2(NUM_CORES);
    localparam int unsigned BankW = $clog2(NUM_BANKS);
    localparam int unsigned WordW = ADDR_W - BankW;
    localparam int unsigned Words = 1 << WordW;

    logic [NUM_BANKS-1:0][NUM_CORES-1:0] grant_all;
    logic [NUM_BANKS-1:0]                rd_all;
    logic [NUM_BANKS-1:0][DATA_W-1:0]    rdata_all;
    logic [NUM_CORES-1:0]                busy;
    logic [NUM_CORES*DATA_W-1:0]         dout_q, dout_d;

    // Cores granted last cycle are in their finish cycle and sit out arbitration once,
    // so a request still held while finish is high is not served twice.
    always_comb begin
        busy = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            busy = busy | grant_all[b];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [CoreW-1:0]     rr_ptr_q, rr_ptr_d;
        logic [NUM_CORES-1:0] elig, win_oh, grant_d, grant_q;
        logic                 win_vld, win_wr, rd_q;
        logic [ADDR_W-1:0]    win_addr;
        logic [WordW-1:0]     win_word;
        logic [DATA_W-1:0]    win_data, rdata_q;
        logic [DATA_W-1:0]    mem_q [Words];

        always_comb begin
            elig     = '0;
            win_oh   = '0;
            win_vld  = 1'b0;
            win_wr   = 1'b0;
            win_addr = '0;
            win_data = '0;
            rr_ptr_d = rr_ptr_q;
            for (int i = 0; i < NUM_CORES; i++) begin
                elig[i] = (read[i] | write[i]) & ~busy[i] &
                          (addr_in[i*ADDR_W +: BankW] == BankW'(b));
            end
            // Round-robin: first eligible at or above the pointer, else wrap to the lowest.
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!win_vld && elig[i] && (CoreW'(i) >= rr_ptr_q)) begin
                    win_oh[i] = 1'b1;
                    win_vld   = 1'b1;
                end
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!win_vld && elig[i]) begin
                    win_oh[i] = 1'b1;
                    win_vld   = 1'b1;
                end
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (win_oh[i]) begin
                    win_wr   = write[i];
                    win_addr = addr_in[i*ADDR_W +: ADDR_W];
                    win_data = data_in[i*DATA_W +: DATA_W];
                    rr_ptr_d = (i == NUM_CORES - 1) ? '0 : CoreW'(i + 1);
                end
            end
            grant_d = win_oh;
            // Co-grant identical-address pure reads; the pointer still moves past the winner only.
            if (COALESCE && win_vld && !win_wr) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (elig[i] && read[i] && !write[i] &&
                        (addr_in[i*ADDR_W +: ADDR_W] == win_addr)) begin
                        grant_d[i] = 1'b1;
                    end
                end
            end
        end

        assign win_word = win_addr[ADDR_W-1:BankW];

        always_ff @(posedge clk) begin
            if (reset) begin
                rr_ptr_q <= '0;
                grant_q  <= '0;
                rd_q     <= 1'b0;
            end else begin
                rr_ptr_q <= rr_ptr_d;
                grant_q  <= grant_d;
                rd_q     <= win_vld & ~win_wr;
            end
        end

        // Storage is not reset.
        always_ff @(posedge clk) begin
            if (!reset && win_vld) begin
                if (win_wr) begin
                    mem_q[win_word] <= win_data;
                end else begin
                    rdata_q <= mem_q[win_word];
                end
            end
        end

        assign grant_all[b] = grant_q;
        assign rd_all[b]    = rd_q;
        assign rdata_all[b] = rdata_q;
    end

    // A core lives on exactly one bank, so at most one bank can hit each lane here.
    always_comb begin
        dout_d = dout_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (rd_all[b] && grant_all[b][i]) begin
                    dout_d[i*DATA_W +: DATA_W] = rdata_all[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    // Reset masks the finish of a grant made in the preceding cycle.
    assign finish   = reset ? '0 : busy;
    assign data_out = reset ? '0 : dout_d;

endmodule
